edu_ctrl_seq: RTL and testbench

- Parametrised, self-contained sequencer for the error decoding unit (EDU).
- Owns the EDU state register, ancilla-measurement round counter, layer round counter and an escalating error-pairing timeout. It drives the per-cycle control pulses that steer the token/cell array.
- Replaces externally held counters and a fixed timeout with internal counters, an adaptive timeout threshold and parameters for code distance and thresholds.

---
 rtl/edu_ctrl_seq.sv | 181 ++++++++++++++++++
 tb/tb_edu_ctrl_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edu_ctrl_seq.sv
// Purpose : EDU sequencer. Owns the state, round and timeout counters and drives the token/cell-array control pulses.
// Latency : state and counters are registered (1 cycle); pulses are combinational from the registered state and current inputs.
// Backpr. : aqmeas entries are popped only in READY/WAITING while fewer than AQMEAS_TH rounds are buffered; otherwise the buffer holds them.
module edu_ctrl_seq #(
    parameter int CODE_DIST     = 5,
    parameter int AQMEAS_TH     = 2,
    parameter int TIMEOUT_INIT  = 2,
    parameter int TIMEOUT_STEP  = 2,
    parameter int TIMEOUT_LIMIT = 6,
    parameter int ROUND_BW      = 4,
    parameter int TIMEOUT_BW    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  aqmeas_valid,
    input  logic                  first_token,
    input  logic                  esmhead_exist,
    input  logic                  last_token,
    input  logic                  global_tokenmatch,
    input  logic                  global_errormatch,
    input  logic                  global_measmatch,
    output logic [1:0]            state,
    output logic [ROUND_BW-1:0]   round_counter,
    output logic [TIMEOUT_BW-1:0] timeout_th,
    output logic                  pop_aqmeasbuf,
    output logic                  shift_token,
    output logic                  rst_cellstate,
    output logic                  layer_retry,
    output logic                  layer_finish,
    output logic                  set_measerr_flag,
    output logic                  set_last_measerr_flag,
    output logic                  esm_finish,
    output logic                  next_valid
);

    typedef enum logic [1:0] {
        ST_READY        = 2'd0,
        ST_TOKENALLOC   = 2'd1,
        ST_ERRORPAIRING = 2'd2,
        ST_WAITING      = 2'd3
    } state_t;

    // Round-counter thresholds, sized once so every comparison is width-matched.
    localparam logic [ROUND_BW-1:0] AQ_TH_R      = ROUND_BW'(AQMEAS_TH);
    localparam logic [ROUND_BW-1:0] RND_ONE      = ROUND_BW'(1);
    localparam logic [ROUND_BW-1:0] RND_LAST     = ROUND_BW'(CODE_DIST - 1);
    localparam logic [ROUND_BW-1:0] RND_MEAS_LO  = ROUND_BW'(AQMEAS_TH - 1);
    // Rounds below this still need fresh ancilla data before the next sweep;
    // zero when AQMEAS_TH==CODE_DIST, so WAITING is then unreachable.
    localparam logic [ROUND_BW-1:0] RND_WAIT_LIM = ROUND_BW'(CODE_DIST - AQMEAS_TH);

    // Timeout constants.
    localparam logic [TIMEOUT_BW-1:0] TO_ONE   = TIMEOUT_BW'(1);
    localparam logic [TIMEOUT_BW-1:0] TO_INIT  = TIMEOUT_BW'(TIMEOUT_INIT);
    localparam logic [TIMEOUT_BW-1:0] TO_STEP  = TIMEOUT_BW'(TIMEOUT_STEP);
    localparam logic [TIMEOUT_BW-1:0] TO_LIMIT = TIMEOUT_BW'(TIMEOUT_LIMIT);

    state_t                  state_q;
    logic [ROUND_BW-1:0]     aqmeas_cnt;
    logic [TIMEOUT_BW-1:0]   timeout_cnt;

    logic                    token_finish;
    logic                    retry_cond;
    logic                    measerr_cond;
    logic                    round_is_last;
    logic                    aq_full;
    logic                    pair_exit;
    logic [TIMEOUT_BW-1:0]   timeout_cnt_inc;
    logic [TIMEOUT_BW-1:0]   th_bumped;
    logic [TIMEOUT_BW-1:0]   th_retry;

    assign state = state_q;

    // Decode conditions shared by the pulse logic and the sequencer.
    always_comb begin
        token_finish    = (first_token & ~esmhead_exist) | last_token;
        retry_cond      = token_finish & esmhead_exist & (timeout_th < TO_LIMIT);
        // An unpaired head after the longest timeout is treated as a measurement
        // error, but only in rounds where enough ancilla history exists.
        measerr_cond    = token_finish & esmhead_exist & (timeout_th == TO_LIMIT)
                          & (round_counter >= RND_MEAS_LO) & (round_counter <= RND_LAST);
        round_is_last   = (round_counter == RND_LAST);
        aq_full         = (aqmeas_cnt == AQ_TH_R);
        // The counter advances every pairing cycle, so the exit test looks at
        // the post-increment value: a threshold of N gives N pairing cycles.
        timeout_cnt_inc = timeout_cnt + TO_ONE;
        pair_exit       = (timeout_cnt_inc >= timeout_th) | global_errormatch | global_measmatch;
        th_bumped       = timeout_th + TO_STEP;
        th_retry        = (th_bumped > TO_LIMIT) ? TO_LIMIT : th_bumped;
    end

    // Per-cycle control pulses, all held low during reset.
    always_comb begin
        pop_aqmeasbuf         = 1'b0;
        shift_token           = 1'b0;
        rst_cellstate         = 1'b0;
        layer_retry           = 1'b0;
        layer_finish          = 1'b0;
        set_measerr_flag      = 1'b0;
        set_last_measerr_flag = 1'b0;
        esm_finish            = 1'b0;
        next_valid            = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_READY, ST_WAITING: begin
                    pop_aqmeasbuf = aqmeas_valid & (aqmeas_cnt < AQ_TH_R);
                end
                ST_TOKENALLOC: begin
                    shift_token = 1'b1;
                    // A token meeting a syndrome head takes precedence over
                    // ending or retrying the layer in the same cycle.
                    if (!global_tokenmatch) begin
                        layer_retry  = retry_cond;
                        layer_finish = token_finish & ~retry_cond;
                    end
                    set_measerr_flag      = measerr_cond;
                    set_last_measerr_flag = measerr_cond & round_is_last;
                    esm_finish            = layer_finish & round_is_last;
                    next_valid            = layer_finish & round_is_last;
                end
                ST_ERRORPAIRING: begin
                    rst_cellstate = pair_exit;
                end
                default: ;
            endcase
        end
    end

    // Sequencer: state register plus round, ancilla and timeout counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_READY;
            aqmeas_cnt    <= '0;
            round_counter <= '0;
            timeout_cnt   <= '0;
            timeout_th    <= TO_INIT;
        end else begin
            case (state_q)
                ST_READY, ST_WAITING: begin
                    if (aq_full) begin
                        state_q    <= ST_TOKENALLOC;
                        aqmeas_cnt <= '0;
                    end else if (pop_aqmeasbuf) begin
                        aqmeas_cnt <= aqmeas_cnt + RND_ONE;
                    end
                end
                ST_TOKENALLOC: begin
                    if (global_tokenmatch) begin
                        state_q     <= ST_ERRORPAIRING;
                        timeout_cnt <= '0;
                    end else if (layer_finish) begin
                        timeout_th <= TO_INIT;
                        if (round_counter < RND_WAIT_LIM) begin
                            state_q       <= ST_WAITING;
                            round_counter <= round_counter + RND_ONE;
                        end else if (round_is_last) begin
                            state_q       <= ST_READY;
                            round_counter <= '0;
                        end else begin
                            round_counter <= round_counter + RND_ONE;
                        end
                    end else if (layer_retry) begin
                        timeout_th <= th_retry;
                    end
                end
                ST_ERRORPAIRING: begin
                    if (pair_exit) begin
                        state_q     <= ST_TOKENALLOC;
                        timeout_cnt <= '0;
                    end else begin
                        timeout_cnt <= timeout_cnt_inc;
                    end
                end
                default: begin
                    state_q <= ST_READY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edu_ctrl_seq.sv
// Purpose : self-checking bench for edu_ctrl_seq: directed vector table then randomized run against a reference model.
// Latency : inputs driven on the falling edge, outputs sampled 2 ns later, state advances on the rising edge.
// Backpr. : n/a (bench drives every input directly).
module tb_edu_ctrl_seq;

    localparam int CD      = 5;
    localparam int AQ_TH   = 2;
    localparam int TO_INIT = 2;
    localparam int TO_STEP = 2;
    localparam int TO_LIM  = 6;
    localparam int N_RAND  = 3000;

    logic       clk = 1'b0;
    logic       rst, aqmeas_valid, first_token, esmhead_exist, last_token;
    logic       global_tokenmatch, global_errormatch, global_measmatch;
    logic [1:0] state;
    logic [3:0] round_counter;
    logic [4:0] timeout_th;
    logic       pop_aqmeasbuf, shift_token, rst_cellstate, layer_retry, layer_finish;
    logic       set_measerr_flag, set_last_measerr_flag, esm_finish, next_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    edu_ctrl_seq dut (
        .clk                   (clk),
        .rst                   (rst),
        .aqmeas_valid          (aqmeas_valid),
        .first_token           (first_token),
        .esmhead_exist         (esmhead_exist),
        .last_token            (last_token),
        .global_tokenmatch     (global_tokenmatch),
        .global_errormatch     (global_errormatch),
        .global_measmatch      (global_measmatch),
        .state                 (state),
        .round_counter         (round_counter),
        .timeout_th            (timeout_th),
        .pop_aqmeasbuf         (pop_aqmeasbuf),
        .shift_token           (shift_token),
        .rst_cellstate         (rst_cellstate),
        .layer_retry           (layer_retry),
        .layer_finish          (layer_finish),
        .set_measerr_flag      (set_measerr_flag),
        .set_last_measerr_flag (set_last_measerr_flag),
        .esm_finish            (esm_finish),
        .next_valid            (next_valid)
    );

    // Inputs {rst,aqv,first,head,last,tokenmatch,errormatch,measmatch};
    // pulses {pop,shift,rst_cell,retry,finish,measerr,last_measerr,esm_finish,next_valid}.
    typedef struct packed {
        logic [7:0] in;
        logic [1:0] st;
        logic [3:0] rnd;
        logic [4:0] th;
        logic [8:0] pul;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] in, input int st, input int rnd,
                                input int th, input logic [8:0] pul);
        vec_t v;
        v.in  = in;
        v.st  = 2'(st);
        v.rnd = 4'(rnd);
        v.th  = 5'(th);
        v.pul = pul;
        return v;
    endfunction

    function automatic logic [8:0] dut_pulses();
        return {pop_aqmeasbuf, shift_token, rst_cellstate, layer_retry, layer_finish,
                set_measerr_flag, set_last_measerr_flag, esm_finish, next_valid};
    endfunction

    task automatic drive(input logic [7:0] in);
        {rst, aqmeas_valid, first_token, esmhead_exist, last_token,
         global_tokenmatch, global_errormatch, global_measmatch} = in;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Reference model: spec rules written with plain integers.
    int m_st, m_aq, m_rnd, m_cyc, m_th;

    task automatic model_reset();
        m_st = 0; m_aq = 0; m_rnd = 0; m_cyc = 0; m_th = TO_INIT;
    endtask

    function automatic logic [8:0] model_pulses(input logic [7:0] in);
        bit r, aqv, fi, hd, la, tm, em, mm;
        bit pop, sh, rc, rt, fn, me, lme, ef, tf;
        {r, aqv, fi, hd, la, tm, em, mm} = in;
        {pop, sh, rc, rt, fn, me, lme, ef} = '0;
        if (!r) begin
            if (m_st == 0 || m_st == 3) pop = aqv && (m_aq < AQ_TH);
            if (m_st == 1) begin
                sh  = 1;
                tf  = (fi && !hd) || la;
                rt  = !tm && tf && hd && (m_th < TO_LIM);
                fn  = !tm && tf && !(hd && (m_th < TO_LIM));
                me  = tf && hd && (m_th == TO_LIM) && (m_rnd >= AQ_TH - 1) && (m_rnd <= CD - 1);
                lme = me && (m_rnd == CD - 1);
                ef  = fn && (m_rnd == CD - 1);
            end
            if (m_st == 2) rc = (m_cyc + 1 >= m_th) || em || mm;
        end
        return {pop, sh, rc, rt, fn, me, lme, ef, ef};
    endfunction

    task automatic model_step(input logic [7:0] in, input logic [8:0] p);
        if (in[7]) begin
            model_reset();
        end else if (m_st == 0 || m_st == 3) begin
            if (m_aq == AQ_TH) begin m_st = 1; m_aq = 0; end
            else if (p[8]) m_aq++;
        end else if (m_st == 1) begin
            if (in[2]) begin
                m_st = 2; m_cyc = 0;
            end else if (p[4]) begin
                m_th = TO_INIT;
                if (m_rnd < CD - AQ_TH) begin m_st = 3; m_rnd++; end
                else if (m_rnd == CD - 1) begin m_st = 0; m_rnd = 0; end
                else m_rnd++;
            end else if (p[5]) begin
                m_th = (m_th + TO_STEP > TO_LIM) ? TO_LIM : m_th + TO_STEP;
            end
        end else begin
            if (p[6]) begin m_st = 1; m_cyc = 0; end
            else m_cyc++;
        end
    endtask

    initial begin
        // Directed walk through the test plan, starting just after a reset edge.
        tbl.push_back(mk(8'b1100_0000, 0, 0, 2, 9'b000000000)); // rst held, pulses forced 0
        tbl.push_back(mk(8'b1100_0000, 0, 0, 2, 9'b000000000));
        tbl.push_back(mk(8'b0100_0000, 0, 0, 2, 9'b100000000)); // pop 1
        tbl.push_back(mk(8'b0100_0000, 0, 0, 2, 9'b100000000)); // pop 2
        tbl.push_back(mk(8'b0100_0000, 0, 0, 2, 9'b000000000)); // full: pop refused
        tbl.push_back(mk(8'b0010_0000, 1, 0, 2, 9'b010010000)); // first token, no head: finish
        tbl.push_back(mk(8'b0100_0000, 3, 1, 2, 9'b100000000)); // WAITING refills
        tbl.push_back(mk(8'b0100_0000, 3, 1, 2, 9'b100000000));
        tbl.push_back(mk(8'b0000_0000, 3, 1, 2, 9'b000000000));
        tbl.push_back(mk(8'b0001_1000, 1, 1, 2, 9'b010100000)); // retry 2->4
        tbl.push_back(mk(8'b0001_1000, 1, 1, 4, 9'b010100000)); // retry 4->6
        tbl.push_back(mk(8'b0001_1000, 1, 1, 6, 9'b010011000)); // limit: finish + measerr
        tbl.push_back(mk(8'b0100_0000, 3, 2, 2, 9'b100000000));
        tbl.push_back(mk(8'b0100_0000, 3, 2, 2, 9'b100000000));
        tbl.push_back(mk(8'b0000_0000, 3, 2, 2, 9'b000000000));
        tbl.push_back(mk(8'b0001_1000, 1, 2, 2, 9'b010100000)); // retry 2->4
        tbl.push_back(mk(8'b0001_1100, 1, 2, 4, 9'b010000000)); // tokenmatch masks retry
        tbl.push_back(mk(8'b0000_0000, 2, 2, 4, 9'b000000000)); // pairing cycle 1
        tbl.push_back(mk(8'b0000_0000, 2, 2, 4, 9'b000000000));
        tbl.push_back(mk(8'b0000_0000, 2, 2, 4, 9'b000000000));
        tbl.push_back(mk(8'b0000_0000, 2, 2, 4, 9'b001000000)); // cycle 4: timeout exit
        tbl.push_back(mk(8'b0000_0100, 1, 2, 4, 9'b010000000)); // tokenmatch again
        tbl.push_back(mk(8'b0000_0000, 2, 2, 4, 9'b000000000));
        tbl.push_back(mk(8'b0000_0010, 2, 2, 4, 9'b001000000)); // errormatch on cycle 2
        tbl.push_back(mk(8'b0010_0000, 1, 2, 4, 9'b010010000)); // finish, th reloads
        tbl.push_back(mk(8'b0100_0000, 3, 3, 2, 9'b100000000));
        tbl.push_back(mk(8'b0100_0000, 3, 3, 2, 9'b100000000));
        tbl.push_back(mk(8'b0000_0000, 3, 3, 2, 9'b000000000));
        tbl.push_back(mk(8'b0010_0000, 1, 3, 2, 9'b010010000)); // round 3: stays in TOKENALLOC
        tbl.push_back(mk(8'b0001_1000, 1, 4, 2, 9'b010100000));
        tbl.push_back(mk(8'b0001_1000, 1, 4, 4, 9'b010100000));
        tbl.push_back(mk(8'b0001_1000, 1, 4, 6, 9'b010011111)); // last round: window done
        tbl.push_back(mk(8'b0000_0000, 0, 0, 2, 9'b000000000));
        tbl.push_back(mk(8'b0100_0000, 0, 0, 2, 9'b100000000));
        tbl.push_back(mk(8'b0100_0000, 0, 0, 2, 9'b100000000));
        tbl.push_back(mk(8'b0000_0000, 0, 0, 2, 9'b000000000));
        tbl.push_back(mk(8'b0001_1000, 1, 0, 2, 9'b010100000));
        tbl.push_back(mk(8'b0001_1000, 1, 0, 4, 9'b010100000));
        tbl.push_back(mk(8'b0000_0100, 1, 0, 6, 9'b010000000)); // enter pairing with th=6
        tbl.push_back(mk(8'b0000_0000, 2, 0, 6, 9'b000000000));
        tbl.push_back(mk(8'b0000_0000, 2, 0, 6, 9'b000000000));
        tbl.push_back(mk(8'b0000_0000, 2, 0, 6, 9'b000000000)); // timeout_cnt now 3
        tbl.push_back(mk(8'b1000_0010, 2, 0, 6, 9'b000000000)); // rst wins over errormatch
        tbl.push_back(mk(8'b0000_0000, 0, 0, 2, 9'b000000000)); // fully reset
        tbl.push_back(mk(8'b0100_0000, 0, 0, 2, 9'b100000000));
        tbl.push_back(mk(8'b0100_0000, 0, 0, 2, 9'b100000000));
        tbl.push_back(mk(8'b0000_0000, 0, 0, 2, 9'b000000000));
        tbl.push_back(mk(8'b0001_1000, 1, 0, 2, 9'b010100000));
        tbl.push_back(mk(8'b0001_1000, 1, 0, 4, 9'b010100000));
        tbl.push_back(mk(8'b0001_1000, 1, 0, 6, 9'b010010000)); // round 0: no measerr
        tbl.push_back(mk(8'b0000_0000, 3, 1, 2, 9'b000000000));

        drive(8'b1000_0000);
        @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].in);
            #2;
            check("dir_state", i, 32'(state), 32'(tbl[i].st));
            check("dir_round", i, 32'(round_counter), 32'(tbl[i].rnd));
            check("dir_th", i, 32'(timeout_th), 32'(tbl[i].th));
            check("dir_pulses", i, 32'(dut_pulses()), 32'(tbl[i].pul));
            @(posedge clk);
        end

        // Randomized run against the reference model.
        @(negedge clk);
        drive(8'b1000_0000);
        @(posedge clk);
        model_reset();
        for (int i = 0; i < N_RAND; i++) begin
            logic [7:0] in;
            logic [8:0] exp_p;
            in[7] = ($urandom_range(99) == 0);
            in[6] = ($urandom_range(1) == 0);
            in[5] = ($urandom_range(3) == 0);
            in[4] = ($urandom_range(1) == 0);
            in[3] = ($urandom_range(4) == 0);
            in[2] = ($urandom_range(6) == 0);
            in[1] = ($urandom_range(9) == 0);
            in[0] = ($urandom_range(9) == 0);
            @(negedge clk);
            drive(in);
            #2;
            exp_p = model_pulses(in);
            check("rnd_state", i, 32'(state), 32'(m_st));
            check("rnd_round", i, 32'(round_counter), 32'(m_rnd));
            check("rnd_th", i, 32'(timeout_th), 32'(m_th));
            check("rnd_pulses", i, 32'(dut_pulses()), 32'(exp_p));
            model_step(in, exp_p);
            @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
